// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_pkg
// Description : Shared definitions for the VRAM fetch block: default memory
//               address/data widths and the fetch FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_pkg;

    // Default word-address and data widths of the video memory port.
    localparam int C_AW_DEFAULT = 19;
    localparam int C_DW_DEFAULT = 16;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD1    = 2'd1,
        RD2    = 2'd2,
        COMMIT = 2'd3
    } state_t;

endpackage : vram_pkg
`default_nettype wire

// File: rtl/vram_toggle_det.sv
`default_nettype none
// ============================================================================
// Module      : vram_toggle_det
// Description : Turns every level change of the fetch toggle into a
//               single-cycle request pulse.
//               Ports:
//                 clk    - clock
//                 rst_n  - asynchronous active-low reset
//                 i_rd   - fetch toggle from the video controller
//                 o_req  - one-cycle request pulse
// Revision    : 1.0 - initial release
// ============================================================================
module vram_toggle_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rd,
    output logic o_req
);
    import vram_pkg::*;

    logic r_rd_d;
    logic r_armed;

    // r_rd_d follows the toggle every cycle, including the first cycle after
    // reset release while r_armed is still low; the level present at release
    // is therefore absorbed and never seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_d  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_rd_d  <= i_rd;
            r_armed <= 1'b1;
        end
    end

    // Combinational so the addresses are latched on the same edge that the
    // toggle is detected.
    assign o_req = r_armed & (i_rd ^ r_rd_d);

endmodule : vram_toggle_det
`default_nettype wire

// File: rtl/vram_fetch.sv
`default_nettype none
// ============================================================================
// Module      : vram_fetch
// Description : Fetches a pair of VRAM words per toggle of vram_rd using a
//               simple req/ack memory port, and presents both words at once.
//               Ports:
//                 CLK_VIDEO              - master clock (rising edge)
//                 reset_n                - asynchronous active-low reset
//                 vram_rd                - fetch toggle, one fetch per change
//                 vram_addr1/vram_addr2  - word addresses of the pair
//                 vram_dout1/vram_dout2  - fetched pair, updated together
//                 mem_req/mem_addr       - memory read request (level)
//                 mem_ack/mem_din        - one-cycle ack with read data
//                 busy                   - fetch active or queued
//                 overrun                - sticky: toggle during a fetch
// Revision    : 1.0 - initial release
// ============================================================================
module vram_fetch
    import vram_pkg::*;
#(
    parameter int AW = C_AW_DEFAULT,
    parameter int DW = C_DW_DEFAULT
) (
    input  logic          CLK_VIDEO,
    input  logic          reset_n,
    input  logic          vram_rd,
    input  logic [AW-1:0] vram_addr1,
    input  logic [AW-1:0] vram_addr2,
    output logic [DW-1:0] vram_dout1,
    output logic [DW-1:0] vram_dout2,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_din,
    output logic          busy,
    output logic          overrun
);

    state_t        r_state;
    state_t        w_next;
    logic          w_req;
    logic          w_mem_req;
    logic [AW-1:0] w_mem_addr;

    logic [AW-1:0] r_a1;
    logic [AW-1:0] r_a2;
    logic [AW-1:0] r_p1;
    logic [AW-1:0] r_p2;
    logic          r_pending;
    logic          r_overrun;
    logic [DW-1:0] r_buf1;
    logic [DW-1:0] r_buf2;
    logic [DW-1:0] r_dout1;
    logic [DW-1:0] r_dout2;

    vram_toggle_det u_toggle_det (
        .clk   (CLK_VIDEO),
        .rst_n (reset_n),
        .i_rd  (vram_rd),
        .o_req (w_req)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_VIDEO or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and memory-port outputs. The request is decoded from the
    // registered state only, so it holds steady until the ack and drops
    // immediately when reset forces the state back to IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_mem_req  = 1'b0;
        w_mem_addr = '0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next = RD1;
                end
            end
            RD1: begin
                w_mem_req  = 1'b1;
                w_mem_addr = r_a1;
                if (mem_ack) begin
                    w_next = RD2;
                end
            end
            RD2: begin
                w_mem_req  = 1'b1;
                w_mem_addr = r_a2;
                if (mem_ack) begin
                    w_next = COMMIT;
                end
            end
            COMMIT: begin
                // A toggle arriving on the exit cycle is queued rather than lost.
                if (w_req || r_pending) begin
                    w_next = RD1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address latches, data buffers, pending queue and output pair
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_VIDEO or negedge reset_n) begin
        if (!reset_n) begin
            r_a1      <= '0;
            r_a2      <= '0;
            r_p1      <= '0;
            r_p2      <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_buf1    <= '0;
            r_buf2    <= '0;
            r_dout1   <= '0;
            r_dout2   <= '0;
        end else begin
            if (w_req && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_a1 <= vram_addr1;
                        r_a2 <= vram_addr2;
                    end
                end
                RD1: begin
                    if (mem_ack) begin
                        r_buf1 <= mem_din;
                    end
                    // Single-entry queue: a newer toggle overwrites an older one.
                    if (w_req) begin
                        r_pending <= 1'b1;
                        r_p1      <= vram_addr1;
                        r_p2      <= vram_addr2;
                    end
                end
                RD2: begin
                    if (mem_ack) begin
                        r_buf2 <= mem_din;
                    end
                    if (w_req) begin
                        r_pending <= 1'b1;
                        r_p1      <= vram_addr1;
                        r_p2      <= vram_addr2;
                    end
                end
                COMMIT: begin
                    // Both words land on the same edge so the pair is never torn.
                    r_dout1   <= r_buf1;
                    r_dout2   <= r_buf2;
                    r_pending <= 1'b0;
                    // A toggle on this cycle is the newest request and wins
                    // over any queued one.
                    if (w_req) begin
                        r_a1 <= vram_addr1;
                        r_a2 <= vram_addr2;
                    end else if (r_pending) begin
                        r_a1 <= r_p1;
                        r_a2 <= r_p2;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_req    = w_mem_req;
    assign mem_addr   = w_mem_addr;
    assign vram_dout1 = r_dout1;
    assign vram_dout2 = r_dout2;
    assign busy       = (r_state != IDLE) | r_pending;
    assign overrun    = r_overrun;

endmodule : vram_fetch
`default_nettype wire

// File: tb/tb_vram_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_fetch
// Description : Self-checking bench for vram_fetch. A transaction-level model
//               predicts the memory port and output pair every cycle; directed
//               scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_fetch;

    localparam int AW = 19;
    localparam int DW = 16;

    logic          CLK_VIDEO;
    logic          reset_n;
    logic          vram_rd;
    logic [AW-1:0] vram_addr1;
    logic [AW-1:0] vram_addr2;
    logic [DW-1:0] vram_dout1;
    logic [DW-1:0] vram_dout2;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_din;
    logic          busy;
    logic          overrun;

    int n_vec;
    int n_err;

    vram_fetch #(.AW(AW), .DW(DW)) u_dut (
        .CLK_VIDEO  (CLK_VIDEO),
        .reset_n    (reset_n),
        .vram_rd    (vram_rd),
        .vram_addr1 (vram_addr1),
        .vram_addr2 (vram_addr2),
        .vram_dout1 (vram_dout1),
        .vram_dout2 (vram_dout2),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_din    (mem_din),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial CLK_VIDEO = 1'b0;
    always #5 CLK_VIDEO = ~CLK_VIDEO;

    // Memory contents seen by the fetcher.
    function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
        if (a == 19'h01234) return 16'hA55A;
        if (a == 19'h05234) return 16'h3CC3;
        return a[15:0] ^ 16'h8001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory responder: acks a held request after ack_dly cycles
    // ------------------------------------------------------------------
    int   ack_dly;
    int   ack_cnt;
    logic resp_en;

    always @(negedge CLK_VIDEO) begin
        if (!resp_en) begin
            ack_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            ack_cnt = mem_req ? 1 : 0;
        end else if (mem_req) begin
            if (ack_cnt == ack_dly) begin
                mem_ack = 1'b1;
                mem_din = memfn(mem_addr);
                ack_cnt = 0;
            end else begin
                ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    // ------------------------------------------------------------------
    // Transaction model: a fetch owes two acks and then one commit edge;
    // toggles during a fetch queue at most one pair and raise overrun.
    // ------------------------------------------------------------------
    logic          m_armed, m_rdd, m_active, m_pend, m_ovr;
    int            m_nack;
    logic [AW-1:0] m_a1, m_a2, m_p1, m_p2;
    logic [DW-1:0] m_d1, m_d2;
    logic          m_tog;
    logic          e_req;
    logic [AW-1:0] e_addr;
    logic          e_busy;

    assign m_tog  = m_armed && (vram_rd != m_rdd);
    assign e_req  = m_active && (m_nack < 2);
    assign e_addr = (m_nack == 0) ? m_a1 : m_a2;
    assign e_busy = m_active || m_pend;

    always @(posedge CLK_VIDEO or negedge reset_n) begin
        if (!reset_n) begin
            m_armed <= 1'b0; m_rdd <= 1'b0; m_active <= 1'b0; m_pend <= 1'b0;
            m_ovr <= 1'b0; m_nack <= 0; m_a1 <= '0; m_a2 <= '0;
            m_p1 <= '0; m_p2 <= '0; m_d1 <= '0; m_d2 <= '0;
        end else begin
            m_rdd   <= vram_rd;
            m_armed <= 1'b1;
            if (!m_active) begin
                if (m_tog) begin
                    m_active <= 1'b1; m_nack <= 0;
                    m_a1 <= vram_addr1; m_a2 <= vram_addr2;
                end
            end else if (m_nack == 2) begin
                m_d1 <= memfn(m_a1); m_d2 <= memfn(m_a2);
                m_pend <= 1'b0; m_nack <= 0;
                if (m_tog) begin
                    m_ovr <= 1'b1; m_a1 <= vram_addr1; m_a2 <= vram_addr2;
                end else if (m_pend) begin
                    m_a1 <= m_p1; m_a2 <= m_p2;
                end else begin
                    m_active <= 1'b0;
                end
            end else begin
                if (m_tog) begin
                    m_ovr <= 1'b1; m_pend <= 1'b1;
                    m_p1 <= vram_addr1; m_p2 <= vram_addr2;
                end
                if (mem_ack) m_nack <= m_nack + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare, after the falling-edge stimulus has settled
    // ------------------------------------------------------------------
    logic          s_req, s_ack;
    logic [AW-1:0] s_addr;

    initial begin
        s_req = 1'b0; s_ack = 1'b0; s_addr = '0;
    end

    always @(negedge CLK_VIDEO) begin
        #1;
        check("mem_req", mem_req, e_req);
        if (e_req) check("mem_addr", mem_addr, e_addr);
        check("dout1", vram_dout1, m_d1);
        check("dout2", vram_dout2, m_d2);
        check("overrun", overrun, m_ovr);
        check("busy", busy, e_busy);
        if (reset_n && s_req && !s_ack) begin
            check("req_hold", mem_req, 1'b1);
            check("addr_hold", mem_addr, s_addr);
        end
        s_req  = reset_n ? mem_req : 1'b0;
        s_ack  = mem_ack;
        s_addr = mem_addr;
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic toggle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        vram_addr1 = a1;
        vram_addr2 = a2;
        vram_rd    = ~vram_rd;
    endtask

    task automatic wait_idle(input int max_cyc);
        int k;
        for (k = 0; k < max_cyc; k++) begin
            @(negedge CLK_VIDEO);
            if (!busy) break;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0;
        reset_n = 1'b0; vram_rd = 1'b1; vram_addr1 = '0; vram_addr2 = '0;
        mem_ack = 1'b0; mem_din = '0; resp_en = 1'b1; ack_dly = 1; ack_cnt = 0;

        // Reset values, then release with the toggle held high.
        repeat (3) @(negedge CLK_VIDEO);
        check("rst_dout1", vram_dout1, 16'h0);
        check("rst_dout2", vram_dout2, 16'h0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_mem_addr", mem_addr, 19'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK_VIDEO);
            check("rel_no_req", mem_req, 1'b0);
            check("rel_busy", busy, 1'b0);
        end

        // Re-reset with the toggle low so the basic fetch is a 0->1 edge.
        reset_n = 1'b0; vram_rd = 1'b0;
        repeat (2) @(negedge CLK_VIDEO);
        reset_n = 1'b1;
        repeat (2) @(negedge CLK_VIDEO);

        // Basic fetch, ack one cycle after request.
        toggle(19'h01234, 19'h05234);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK_VIDEO);
            if (k == 0) begin
                check("f1_req", mem_req, 1'b1);
                check("f1_addr1", mem_addr, 19'h01234);
            end
            if (k == 2) check("f1_addr2", mem_addr, 19'h05234);
            if (k == 4) begin
                check("f1_pre_d1", vram_dout1, 16'h0);
                check("f1_pre_d2", vram_dout2, 16'h0);
            end
            if (k == 5) begin
                check("f1_d1", vram_dout1, 16'hA55A);
                check("f1_d2", vram_dout2, 16'h3CC3);
            end
        end
        wait_idle(20);

        // Slow memory: request held for six cycles per word.
        ack_dly = 6;
        toggle(19'h00100, 19'h00200);
        repeat (5) @(negedge CLK_VIDEO);
        check("slow_hold_d1", vram_dout1, 16'hA55A);
        check("slow_req", mem_req, 1'b1);
        check("slow_addr", mem_addr, 19'h00100);
        wait_idle(60);
        check("slow_d1", vram_dout1, 16'h8101);
        check("slow_d2", vram_dout2, 16'h8201);
        ack_dly = 1;

        // Overrun: toggle during RD2, then two toggles during the queued fetch.
        toggle(19'h00300, 19'h00400);
        repeat (3) @(negedge CLK_VIDEO);
        toggle(19'h00010, 19'h00020);
        @(negedge CLK_VIDEO);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_busy", busy, 1'b1);
        repeat (2) @(negedge CLK_VIDEO);
        check("ovr_next_req", mem_req, 1'b1);
        check("ovr_next_addr", mem_addr, 19'h00010);
        toggle(19'h00050, 19'h00060);
        @(negedge CLK_VIDEO);
        toggle(19'h00070, 19'h00080);
        wait_idle(60);
        check("ovr_d1", vram_dout1, 16'h8071);
        check("ovr_d2", vram_dout2, 16'h8081);

        // Reset in the middle of RD1, then a stray ack.
        resp_en = 1'b0;
        toggle(19'h00500, 19'h00600);
        repeat (2) @(negedge CLK_VIDEO);
        check("rd1_req", mem_req, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_req_drop", mem_req, 1'b0);
        check("rst_busy_drop", busy, 1'b0);
        @(negedge CLK_VIDEO);
        #2 reset_n = 1'b1;
        @(negedge CLK_VIDEO);
        mem_ack = 1'b1; mem_din = 16'hBEEF;
        @(negedge CLK_VIDEO);
        mem_ack = 1'b0;
        repeat (3) @(negedge CLK_VIDEO);
        check("stray_d1", vram_dout1, 16'h0);
        check("stray_d2", vram_dout2, 16'h0);
        check("stray_req", mem_req, 1'b0);
        check("stray_busy", busy, 1'b0);
        resp_en = 1'b1;

        // Toggle landing on the commit cycle must still be fetched.
        toggle(19'h00700, 19'h00800);
        repeat (5) @(negedge CLK_VIDEO);
        toggle(19'h00900, 19'h00A00);
        wait_idle(40);
        check("cmt_d1", vram_dout1, 16'h8901);
        check("cmt_d2", vram_dout2, 16'h8A01);
        check("cmt_ovr", overrun, 1'b1);

        repeat (3) @(negedge CLK_VIDEO);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_vram_fetch
`default_nettype wire

// File: doc/vram_fetch.md
VRAM_FETCH -- requirements
Module: vram_fetch

Interface
REQ-001 Parameter AW, default 19, memory word-address width.
REQ-002 Parameter DW, default 16, memory data width.
REQ-003 CLK_VIDEO  input  1  master clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 vram_rd  input  1  fetch request toggle from the video controller; every level change requests one fetch.
REQ-006 vram_addr1  input  AW  first word address, sampled on the cycle the toggle is detected.
REQ-007 vram_addr2  input  AW  second word address, sampled with vram_addr1.
REQ-008 vram_dout1  output  DW  data read from vram_addr1.
REQ-009 vram_dout2  output  DW  data read from vram_addr2.
REQ-010 mem_req  output  1  memory read request, level.
REQ-011 mem_addr  output  AW  memory read address.
REQ-012 mem_ack  input  1  one-cycle strobe; mem_din is valid in the same cycle.
REQ-013 mem_din  input  DW  memory read data.
REQ-014 busy  output  1  high while the FSM is not IDLE or a fetch is pending.
REQ-015 overrun  output  1  sticky flag: a toggle arrived while a fetch was in progress.

Function
REQ-016 Toggle detect: register vram_rd_d; a request occurs when vram_rd differs from vram_rd_d, with the armed flag set.
REQ-017 armed clears on reset and sets one cycle after release; vram_rd_d loads every cycle, so the level at reset release never triggers.
REQ-018 FSM states are IDLE, RD1, RD2, COMMIT.
REQ-019 IDLE + request: latch both addresses into a1/a2, go to RD1.
REQ-020 RD1: mem_req=1, mem_addr=a1; on mem_ack capture mem_din into buf1 and go to RD2.
REQ-021 RD2: mem_req=1, mem_addr=a2; on mem_ack capture mem_din into buf2 and go to COMMIT.
REQ-022 COMMIT: load vram_dout1<=buf1 and vram_dout2<=buf2 in the same cycle, so the pair is never torn; go to IDLE, or to RD1 if a fetch is pending.
REQ-023 mem_req and mem_addr stay stable from assertion until mem_ack; mem_req is low in IDLE and COMMIT.
REQ-024 mem_ack outside RD1/RD2 is ignored; no data is captured.
REQ-025 Request while not IDLE: set overrun, set pending, latch new addresses into p1/p2; COMMIT then transfers p1/p2 to a1/a2.
REQ-026 Request while pending is already set: overwrite p1/p2 with the newest addresses; only one fetch stays queued.
REQ-027 Request in the same cycle COMMIT exits to IDLE: treated as pending, so it is not lost.
REQ-028 Latency: with mem_ack one cycle after mem_req, vram_dout1/2 update 5 cycles after the toggle edge is sampled; the budget is 32 cycles before the next character-cell load.
REQ-029 No arithmetic; addresses pass through unmodified, word-addressed.

Reset
REQ-030 Asynchronous assertion; the state register returns to IDLE immediately, and mem_req drops without waiting for ack.
REQ-031 Reset values are all zero: vram_dout1, vram_dout2, mem_req, mem_addr, busy, overrun, pending, armed, buffers.
REQ-032 Reset during RD1/RD2 abandons the transaction; a late mem_ack after release is ignored per REQ-024.

Structure
REQ-033 Package vram_pkg holds the AW/DW defaults and the state enum (IDLE, RD1, RD2, COMMIT).
REQ-034 One sub-module, vram_toggle_det, contains vram_rd_d and armed, and outputs a single-cycle request pulse.

Verification
REQ-035 Reset release with vram_rd=1 -> no mem_req for 4 cycles and busy=0.
REQ-036 Toggle 0->1, addr1=0x01234, addr2=0x05234, ack after 1 cycle, mem_din 0xA55A then 0x3CC3 -> mem_addr sequence 0x01234 then 0x05234; dout1=0xA55A and dout2=0x3CC3 5 cycles after the edge, updated in the same cycle.
REQ-037 Ack delayed 6 cycles each -> mem_req and mem_addr stable throughout; dout unchanged until COMMIT.
REQ-038 Second toggle in RD2 with addr1=0x00010 -> overrun=1; the second fetch starts with mem_addr=0x00010 immediately after COMMIT; the third toggle overwrites the queued addresses.
REQ-039 reset_n low during RD1 -> mem_req=0 in the same cycle; a stray mem_ack after release leaves dout=0 and the FSM in IDLE.
